// File: rtl/regfile_write_queue_if.sv
// Handshake, retirement and forwarding signals between a write requester and regfile_write_queue.
interface regfile_write_queue_if #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic                       in_valid;
  logic [ADDR_W-1:0]          in_addr;
  logic [DATA_W-1:0]          in_data;
  logic                       in_ready;
  logic                       hold;
  logic [(1<<ADDR_W)-1:0]     wr_en;
  logic [DATA_W-1:0]          wr_bus;
  logic [ADDR_W-1:0]          rd_addr;
  logic                       rd_hit;
  logic [DATA_W-1:0]          rd_data;
  logic [$clog2(DEPTH+1)-1:0] count;

  modport slave (
    input  in_valid, in_addr, in_data, hold, rd_addr,
    output in_ready, wr_en, wr_bus, rd_hit, rd_data, count
  );
  modport master (
    output in_valid, in_addr, in_data, hold, rd_addr,
    input  in_ready, wr_en, wr_bus, rd_hit, rd_data, count
  );
endinterface

// File: rtl/regfile_write_queue.sv
// In-order write buffer ahead of the register array: one retirement per cycle as a
// one-hot enable plus shared bus, with youngest-match read forwarding over pending writes.
module regfile_write_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_write_queue_if.slave  wq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int NREG  = 1 << ADDR_W;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, idx;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ready_q, push, pop, empty, hit;
  logic [NREG-1:0]   wen;
  logic [DATA_W-1:0] bus, fwd;

  assign empty   = (cnt == '0);
  assign push    = wq.in_valid && ready_q;
  assign pop     = !empty && !wq.hold;
  assign cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);

  // ready is registered so it stays low through reset and only rises on the first edge after release
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      cnt     <= '0;
      ready_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      cnt     <= cnt_nxt;
      ready_q <= (cnt_nxt != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= wq.in_addr;
      data_q[wr_ptr] <= wq.in_data;
    end
  end

  always_comb begin
    wen = '0;
    bus = '0;
    if (!empty) bus = data_q[rd_ptr];
    if (pop)    wen[addr_q[rd_ptr]] = 1'b1;
  end

  // scan oldest to youngest so the last match (youngest) wins
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr + PTR_W'(k);
      if (k < int'(cnt) && addr_q[idx] == wq.rd_addr) begin
        hit = 1'b1;
        fwd = data_q[idx];
      end
    end
  end

  assign wq.in_ready = ready_q;
  assign wq.wr_en    = wen;
  assign wq.wr_bus   = bus;
  assign wq.rd_hit   = hit;
  assign wq.rd_data  = fwd;
  assign wq.count    = cnt;
endmodule
